multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 145 ++++++++++++++
 tb/tb_multdiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply/divide unit with HI/LO result registers
module multdiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [3:0] OP_MULT = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_mag_b;
    logic                r_neg_res;
    logic                r_neg_a;
    logic                r_is_div;
    logic                r_b_zero;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_accept;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_add_sum;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_diff;
    logic                w_fits;
    logic [2*DATA_W-1:0] w_prod_next;
    logic [2*DATA_W-1:0] w_mul_res;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    assign w_accept = (r_state == S_IDLE) && start && ((alu_op == OP_MULT) || (alu_op == OP_DIV));
    assign w_mag_a  = src_a[DATA_W-1] ? (~src_a + 1'b1) : src_a;
    assign w_mag_b  = src_b[DATA_W-1] ? (~src_b + 1'b1) : src_b;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    assign w_add_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_mag_b} : '0);

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_shift = {r_prod[2*DATA_W-1:DATA_W], r_prod[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_mag_b};
    assign w_fits  = (w_shift >= {1'b0, r_mag_b});

    always_comb begin
        w_prod_next = r_prod;
        if (r_is_div) begin
            if (w_fits) begin
                w_prod_next = {w_diff[DATA_W-1:0], r_prod[DATA_W-2:0], 1'b1};
            end else begin
                w_prod_next = {w_shift[DATA_W-1:0], r_prod[DATA_W-2:0], 1'b0};
            end
        end else begin
            w_prod_next = {w_add_sum, r_prod[DATA_W-1:1]};
        end
    end

    assign w_mul_res = r_neg_res ? (~r_prod + 1'b1) : r_prod;
    assign w_quo     = r_b_zero ? '1 :
                       (r_neg_res ? (~r_prod[DATA_W-1:0] + 1'b1) : r_prod[DATA_W-1:0]);
    assign w_rem     = r_neg_a ? (~r_prod[2*DATA_W-1:DATA_W] + 1'b1) : r_prod[2*DATA_W-1:DATA_W];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (r_cnt == LAST_ITER) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_mag_b   <= '0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_is_div  <= 1'b0;
            r_b_zero  <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_prod    <= {{DATA_W{1'b0}}, w_mag_a};
                        r_mag_b   <= w_mag_b;
                        r_neg_res <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
                        r_neg_a   <= src_a[DATA_W-1];
                        r_is_div  <= (alu_op == OP_DIV);
                        r_b_zero  <= (src_b == '0);
                    end
                end
                S_CALC: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_prod <= w_prod_next;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_mul_res[2*DATA_W-1:DATA_W];
                        r_lo <= w_mul_res[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit
module tb_multdiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_errors;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    multdiv_unit #(.DATA_W(32)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_op (alu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is taken at the following posedge (edge N).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        alu_op = op;
        src_a  = a;
        src_b  = b;
        @(negedge clk);
        start  = 1'b0;
        alu_op = 4'd0;
        src_a  = $urandom;
        src_b  = $urandom;
    endtask

    // Entered at the first negedge after edge N (k=0); returns at the negedge where done=1.
    task automatic wait_done(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                             input int inj_k);
        int k;
        int nbusy;
        k = 0;
        nbusy = 0;
        while (!done && k < 100) begin
            if (busy) nbusy++;
            if (k == 16) begin
                check({tag, " hold_hi"}, {32'd0, hi}, {32'd0, prev_hi});
                check({tag, " hold_lo"}, {32'd0, lo}, {32'd0, prev_lo});
            end
            if (k == inj_k) begin
                start = 1'b1; alu_op = 4'd11; src_a = 32'd9; src_b = 32'd3;
            end else if (k == inj_k + 1) begin
                start = 1'b0; alu_op = 4'd0;
            end
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'd33);
        check({tag, " busy_cycles"}, 64'(nbusy), 64'd33);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
        prev_hi = ehi;
        prev_lo = elo;
    endtask

    task automatic op_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        @(negedge clk);
        issue(op, a, b);
        wait_done(tag, ehi, elo, -1);
    endtask

    initial begin
        int ndone;
        n_checks = 0;
        n_errors = 0;
        prev_hi = '0;
        prev_lo = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = 4'd0;
        src_a  = '0;
        src_b  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;

        // Non-MULT/DIV opcode with start must not launch anything
        @(negedge clk);
        start = 1'b1; alu_op = 4'd5; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0; alu_op = 4'd0;
        check("bad_op busy", {63'd0, busy}, 64'd0);

        op_run("mul_7_m3",  4'd10, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        op_run("mul_min2",  4'd10, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        op_run("div_m7_2",  4'd11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        op_run("div_100_0", 4'd11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        op_run("div_ovf",   4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        op_run("div_100_7", 4'd11, 32'd100, 32'd7, 32'd2, 32'd14);
        op_run("div_7_m2",  4'd11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        op_run("div_m5_0",  4'd11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // DIV strobed at N+10 while a MULT runs must be ignored
        @(negedge clk);
        issue(4'd10, 32'd5, 32'd6);
        wait_done("mul_ign", 32'd0, 32'd30, 9);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign extra_done", 64'(ndone), 64'd0);
        check("ign busy", {63'd0, busy}, 64'd0);
        check("ign hi", {32'd0, hi}, 64'd0);
        check("ign lo", {32'd0, lo}, 64'd30);

        // Back-to-back: second request issued in the done cycle
        op_run("b2b_mul", 4'd10, 32'd2, 32'd3, 32'd0, 32'd6);
        issue(4'd11, 32'd9, 32'd4);
        check("b2b done_pulse_width", {63'd0, done}, 64'd0);
        check("b2b second_busy", {63'd0, busy}, 64'd1);
        wait_done("b2b_div", 32'd1, 32'd2, -1);

        // Reset in the middle of CALC
        op_run("pre_rst", 4'd11, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022);
        @(negedge clk);
        issue(4'd10, 32'd3, 32'd4);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst hi", {32'd0, hi}, 64'd0);
        check("rst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst no_done", 64'(ndone), 64'd0);
        check("rst hi_after", {32'd0, hi}, 64'd0);
        prev_hi = '0;
        prev_lo = '0;

        // Request presented together with reset release is taken at the first edge
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd10, 32'hFFFFFFFC, 32'd5);
        wait_done("post_rst", 32'hFFFFFFFF, 32'hFFFFFFEC, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
